// File: rtl/accel_seq_pkg.sv
// Shared definitions for the network-level layer sequencer.
// Contents: sequencer state enum, descriptor op codes (also used by the
// computation controller decode), error codes, default sizing and a small
// op-code legality helper.
package accel_seq_pkg;

  localparam int unsigned DEF_NUM_LAYERS_MAX = 16;
  localparam int unsigned DEF_TIMEOUT_W      = 24;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StPause,
    StIssue,
    StWait,
    StNext,
    StError
  } seq_state_t;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_CONV  = 3'b001;
  localparam logic [2:0] OP_DENSE = 3'b010;
  localparam logic [2:0] OP_POOL  = 3'b011;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_COUNT   = 2'b01;
  localparam logic [1:0] ERR_OP      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // OP_NONE and every 1xx code are illegal inside a descriptor.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_CONV) || (op == OP_DENSE) || (op == OP_POOL);
  endfunction

endpackage

// File: rtl/layer_desc_ram.sv
// Layer descriptor storage: one write port, one registered read port, no reset.
// Ports:
//   i_clk      - clock
//   i_wr_en    - write strobe (already gated by the sequencer)
//   i_wr_addr  - write slot
//   i_wr_data  - descriptor {pause, op[2:0]}
//   i_rd_addr  - read slot
//   o_rd_data  - descriptor at i_rd_addr, one cycle later
module layer_desc_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/layer_sequencer.sv
// Network-level layer sequencer. Walks a host-loaded descriptor list, issues
// each layer to the computation controller and waits for its done edge.
// Ports:
//   i_clk, i_rst          - clock, asynchronous active-high reset
//   i_desc_wr_*           - descriptor load port (accepted in IDLE/ERROR only)
//   i_num_layers          - layer count, 1..NUM_LAYERS_MAX, sampled on i_run
//   i_timeout_limit       - per-layer watchdog limit, 0 disables
//   i_run/i_resume/i_abort/i_err_clr - host controls
//   i_done                - completion from the computation controller
//   o_comp_sel/o_start_comp - layer op and start pulse to the controller
//   o_busy/o_paused/o_cur_layer/o_seq_done/o_err/o_err_code - host status
module layer_sequencer
  import accel_seq_pkg::*;
#(
  parameter int unsigned NUM_LAYERS_MAX = DEF_NUM_LAYERS_MAX,
  parameter int unsigned TIMEOUT_W      = DEF_TIMEOUT_W,
  localparam int unsigned IDX_W         = $clog2(NUM_LAYERS_MAX),
  localparam int unsigned CNT_W         = IDX_W + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_desc_wr_en,
  input  logic [IDX_W-1:0]     i_desc_wr_addr,
  input  logic [3:0]           i_desc_wr_data,
  input  logic [CNT_W-1:0]     i_num_layers,
  input  logic [TIMEOUT_W-1:0] i_timeout_limit,
  input  logic                 i_run,
  input  logic                 i_resume,
  input  logic                 i_abort,
  input  logic                 i_err_clr,
  input  logic                 i_done,
  output logic [2:0]           o_comp_sel,
  output logic                 o_start_comp,
  output logic                 o_busy,
  output logic                 o_paused,
  output logic [IDX_W-1:0]     o_cur_layer,
  output logic                 o_seq_done,
  output logic                 o_err,
  output logic [1:0]           o_err_code
);

  seq_state_t           r_state, w_state_d;
  logic [CNT_W-1:0]     r_num_layers;
  logic [IDX_W-1:0]     r_layer_idx;
  logic [2:0]           r_op;
  logic [TIMEOUT_W-1:0] r_wdog;
  logic                 r_done_q;
  logic                 r_seq_done;
  logic [1:0]           r_err_code;

  logic [3:0]           w_rd_data;
  logic                 w_busy;
  logic                 w_done_rise;
  logic                 w_last;
  logic                 w_count_ok;
  logic [TIMEOUT_W-1:0] w_wdog_cnt;
  logic                 w_seq_done_d;
  logic [1:0]           w_err_code_d;
  logic                 w_load_count;
  logic                 w_idx_inc;
  logic                 w_op_load;
  logic                 w_wdog_clr;
  logic                 w_wdog_inc;

  assign w_busy      = (r_state != StIdle) && (r_state != StError);
  assign w_done_rise = i_done & ~r_done_q;
  assign w_last      = ({1'b0, r_layer_idx} == (r_num_layers - CNT_W'(1)));
  assign w_count_ok  = (i_num_layers != '0) && (i_num_layers <= CNT_W'(NUM_LAYERS_MAX));
  // Count of the current WAIT cycle; the first WAIT cycle counts as 1.
  assign w_wdog_cnt  = r_wdog + TIMEOUT_W'(1);

  layer_desc_ram #(
    .DEPTH (NUM_LAYERS_MAX),
    .WIDTH (4)
  ) u_desc_ram (
    .i_clk     (i_clk),
    .i_wr_en   (i_desc_wr_en & ~w_busy),
    .i_wr_addr (i_desc_wr_addr),
    .i_wr_data (i_desc_wr_data),
    .i_rd_addr (r_layer_idx),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_seq_done_d = 1'b0;
    w_err_code_d = r_err_code;
    w_load_count = 1'b0;
    w_idx_inc    = 1'b0;
    w_op_load    = 1'b0;
    w_wdog_clr   = 1'b0;
    w_wdog_inc   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_run) begin
          if (w_count_ok) begin
            w_load_count = 1'b1;
            w_state_d    = StFetch;
          end else begin
            w_err_code_d = ERR_COUNT;
            w_state_d    = StError;
          end
        end
      end
      StFetch:  w_state_d = StDecode;
      StDecode: begin
        w_op_load = 1'b1;
        if (!op_is_legal(w_rd_data[2:0])) begin
          w_err_code_d = ERR_OP;
          w_state_d    = StError;
        end else if (w_rd_data[3]) begin
          w_state_d = StPause;
        end else begin
          w_state_d = StIssue;
        end
      end
      StPause: begin
        if (i_resume) w_state_d = StIssue;
      end
      StIssue: begin
        w_wdog_clr = 1'b1;
        w_state_d  = StWait;
      end
      StWait: begin
        w_wdog_inc = 1'b1;
        // A done edge beats a watchdog hit in the same cycle.
        if (w_done_rise) begin
          w_state_d = StNext;
        end else if ((i_timeout_limit != '0) && (w_wdog_cnt == i_timeout_limit)) begin
          w_err_code_d = ERR_TIMEOUT;
          w_state_d    = StError;
        end
      end
      StNext: begin
        if (w_last) begin
          w_seq_done_d = 1'b1;
          w_state_d    = StIdle;
        end else begin
          w_idx_inc = 1'b1;
          w_state_d = StFetch;
        end
      end
      StError: begin
        if (i_err_clr) begin
          w_err_code_d = ERR_NONE;
          w_state_d    = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Abort overrides everything while busy and leaves the error code alone.
    if (i_abort && w_busy) begin
      w_state_d    = StIdle;
      w_seq_done_d = 1'b0;
      w_err_code_d = r_err_code;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_num_layers <= '0;
      r_layer_idx  <= '0;
      r_op         <= OP_NONE;
      r_wdog       <= '0;
      r_done_q     <= 1'b0;
      r_seq_done   <= 1'b0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_done_q   <= i_done;
      r_seq_done <= w_seq_done_d;
      r_err_code <= w_err_code_d;
      if (w_load_count) begin
        r_num_layers <= i_num_layers;
        r_layer_idx  <= '0;
      end else if (w_idx_inc) begin
        r_layer_idx <= r_layer_idx + IDX_W'(1);
      end
      if (w_op_load) r_op <= w_rd_data[2:0];
      if (w_wdog_clr) begin
        r_wdog <= '0;
      end else if (w_wdog_inc) begin
        r_wdog <= w_wdog_cnt;
      end
    end
  end

  assign o_comp_sel   = ((r_state == StIssue) || (r_state == StWait)) ? r_op : OP_NONE;
  assign o_start_comp = (r_state == StIssue);
  assign o_busy       = w_busy;
  assign o_paused     = (r_state == StPause);
  assign o_cur_layer  = r_layer_idx;
  assign o_seq_done   = r_seq_done;
  assign o_err        = (r_state == StError);
  assign o_err_code   = r_err_code;

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Network-level sequencer sitting directly upstream of the computation controller. It holds a small host-loaded list of layer descriptors and, on `run`, walks it in order: it drives `comp_sel`, pulses `start_comp`, waits for the controller's `done`, and then advances to the next layer. It reports progress, completion and errors to the host.

## Interface
- `NUM_LAYERS_MAX`, 16, descriptor slots; `cur_layer`/address width = $clog2(NUM_LAYERS_MAX)
- `TIMEOUT_W`, 24, width of the per-layer watchdog counter
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: reset is asynchronous and active-high
- `desc_wr_en` in 1: descriptor write strobe
- `desc_wr_addr` in 4: descriptor slot
- `desc_wr_data` in 4: [2:0] op code, [3] pause-before-layer
- `num_layers` in 5: layers to run, legal 1..16, sampled on `run`
- `timeout_limit` in TIMEOUT_W: per-layer watchdog; 0 disables it
- `run` in 1: start sequence (1-cycle pulse)
- `resume` in 1: release a paused layer
- `abort` in 1: cancel sequence
- `err_clr` in 1: leave ERROR
- `done` in 1: from computation controller
- `comp_sel` out 3: to computation controller
- `start_comp` out 1: to computation controller, 1-cycle pulse
- `busy` out 1: state not IDLE/ERROR
- `paused` out 1: state is PAUSE
- `cur_layer` out 4: index of current layer
- `seq_done` out 1: 1-cycle completion pulse
- `err` out 1: state is ERROR
- `err_code` out 2: 01 bad count, 10 bad op, 11 timeout

## Operation
- Op codes: 000 none, 001 conv, 010 dense, 011 pool. 1xx and 000 are illegal in a descriptor.
- Descriptor RAM: NUM_LAYERS_MAX x 4 bits, not reset. Writes are accepted only in IDLE or ERROR and dropped while busy.
- States and transitions:
  - IDLE: on `run`, `num_layers` in 1..16 latches, `layer_idx`=0 -> FETCH; otherwise ERROR/01.
  - FETCH: RAM read of `desc[layer_idx]` -> DECODE.
  - DECODE: illegal op -> ERROR/10; pause bit set -> PAUSE; else -> ISSUE.
  - PAUSE: on `resume` -> ISSUE.
  - ISSUE: `start_comp`=1 for exactly this cycle, watchdog cleared -> WAIT.
  - WAIT: on rising edge of `done` (`done` & ~`done_q`) -> NEXT; watchdog == `timeout_limit` (nonzero) -> ERROR/11.
  - NEXT: if `layer_idx` == `num_layers`-1 -> IDLE with `seq_done`; else `layer_idx`+1 -> FETCH.
  - ERROR: outputs quiet; on `err_clr` -> IDLE with `err_code` cleared.
- `comp_sel` = latched op during ISSUE and WAIT, 000 elsewhere. This keeps the controller's mux and `done` select stable for the whole layer.
- `done` edge detection: `done_q` is updated every cycle. A `done` already high on entry to WAIT does not count; a fresh edge is required.
- Abort has highest priority. In any state except IDLE/ERROR it forces IDLE next cycle: `comp_sel`=0, no `seq_done`, `err` unchanged.
- Simultaneous events:
  - `run` while busy: ignored.
  - `resume` outside PAUSE: ignored.
  - `done` edge and watchdog hit in the same cycle: done wins.
  - `err_clr` together with `run` in ERROR: clear only.

## Timing
- Reset: state IDLE, `layer_idx`=0, watchdog=0, `done_q`=0. All outputs are 0 (`comp_sel`=000, `err_code`=00).
- `run` sampled at edge N: FETCH in N+1, DECODE in N+2, `start_comp` high in cycle N+3 (no pause).
- `done` edge sampled in cycle M: NEXT in M+1. Next layer's `start_comp` in M+4; for the last layer, `seq_done` is high in M+2 while in IDLE.
- Watchdog counts WAIT cycles from 1. Timeout is declared in the cycle where count == `timeout_limit`; ERROR follows in the next cycle.
- Asynchronous `rst` mid-sequence returns to IDLE immediately; `start_comp` drops in the same instant.

## Structure
- `accel_seq_pkg` contains:
  - state enum `seq_state_t` (IDLE, FETCH, DECODE, PAUSE, ISSUE, WAIT, NEXT, ERROR);
  - op-code constants `OP_NONE/OP_CONV/OP_DENSE/OP_POOL`, shared with the computation controller decode;
  - `ERR_COUNT/ERR_OP/ERR_TIMEOUT`.
- Sub-module `layer_desc_ram`: 1 write port, 1 registered read port, no reset.

## Test plan
- 3 layers {conv, dense, pool}, `run`, bench returns a `done` pulse 10 cycles after each `start_comp` -> `comp_sel` 1,2,3 in order, one `start_comp` each, `seq_done` pulse at last-done+2, `cur_layer` 0..2.
- `num_layers`=0 and =17 -> ERROR, `err_code`=01, no `start_comp`; `err_clr` -> IDLE, `err`=0.
- Descriptor 1 op=110 -> layer 0 runs, then ERROR/10 with `cur_layer`=1 and `comp_sel`=000.
- `timeout_limit`=5, `done` never rises -> ERROR/11 exactly 6 cycles after `start_comp`; repeat with `done` rising on the limit cycle -> no error.
- Layer 1 pause bit set -> `paused`=1 after layer 0 completes; `start_comp` appears 1 cycle after `resume`; a `resume` pulsed earlier is ignored.
- `abort` mid-WAIT with `done` held high -> IDLE next cycle, no `seq_done`. Then `run` -> a fresh `done` edge is required to advance, and a `desc_wr_en` attempted while busy leaves the RAM contents unchanged.
